// File: rtl/c1_pkg.sv
// Shared definitions for the C1 bus slave: command codes, FSM states and default widths.
package c1_pkg;

    localparam int C1_MEM_ADDR_SIZE     = 19;
    localparam int C1_BUS_SIZE          = 16;
    localparam int C1_CACHE_OFFSET_SIZE = 4;

    typedef enum logic [2:0] {
        C1_NOP      = 3'd0,
        C1_READ8    = 3'd1,
        C1_READ16   = 3'd2,
        C1_READ32   = 3'd3,
        C1_INV_LINE = 3'd4,
        C1_WRITE8   = 3'd5,
        C1_WRITE16  = 3'd6,
        C1_WRITE32  = 3'd7
    } c1_cmd_e;

    // The response code shares its encoding with WRITE32 on the wire.
    localparam c1_cmd_e C1_WRITE32_RESP = C1_WRITE32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR2 = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP1 = 3'd4,
        ST_RESP2 = 3'd5
    } c1_state_e;

    function automatic logic is_read(input c1_cmd_e c);
        return (c == C1_READ8) || (c == C1_READ16) || (c == C1_READ32);
    endfunction

endpackage

// File: rtl/c1_tristate.sv
// Registered bus driver: value and output-enable are flopped, then gated onto an inout pad.
module c1_tristate #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    input  logic         oe_d,
    inout  wire  [W-1:0] pad
);

    logic [W-1:0] q;
    logic         oe;

    always_ff @(posedge clk) begin
        if (reset) begin
            q  <= '0;
            oe <= 1'b0;
        end else begin
            q  <= d;
            oe <= oe_d;
        end
    end

    assign pad = oe ? q : {W{1'bz}};

endmodule

// File: rtl/c1_bus_slave.sv
// Cache-side C1 bus front end. Define C1_SLAVE_INV_EN to forward INV_LINE to the core;
// otherwise INV_LINE is acknowledged locally without a core request.
module c1_bus_slave
    import c1_pkg::*;
#(
    parameter int MEM_ADDR_SIZE     = C1_MEM_ADDR_SIZE,
    parameter int BUS_SIZE          = C1_BUS_SIZE,
    parameter int CACHE_OFFSET_SIZE = C1_CACHE_OFFSET_SIZE
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
    inout  wire  [BUS_SIZE-1:0]                     data,
    inout  wire  [2:0]                              command,
    output logic                                    req_valid,
    input  logic                                    req_ready,
    output logic [2:0]                              req_cmd,
    output logic [MEM_ADDR_SIZE-1:0]                req_addr,
    output logic [2*BUS_SIZE-1:0]                   req_wdata,
    input  logic                                    resp_valid,
    input  logic [2*BUS_SIZE-1:0]                   resp_rdata
);

    localparam int TAG_SET_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;

    c1_state_e                    state, next_state;
    c1_cmd_e                      cmd_q;
    logic [TAG_SET_W-1:0]         tag_set_q;
    logic [CACHE_OFFSET_SIZE-1:0] offset_q;
    logic [2*BUS_SIZE-1:0]        wdata_q;
    logic [2*BUS_SIZE-1:0]        rdata_q;

    logic [2:0]          cmd_drv_d;
    logic                cmd_oe_d;
    logic [BUS_SIZE-1:0] data_drv_d;
    logic                data_oe_d;

    // Handshake: a request transfers on the edge where req_valid and req_ready are both high;
    // req_valid stays high and the req_* fields stay stable until then.
    assign req_valid = (state == ST_REQ);
    assign req_cmd   = cmd_q;
    assign req_addr  = {tag_set_q, offset_q};
    assign req_wdata = wdata_q;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (command != C1_NOP) next_state = ST_ADDR2;
`ifdef C1_SLAVE_INV_EN
            ST_ADDR2: next_state = ST_REQ;
`else
            ST_ADDR2: next_state = (cmd_q == C1_INV_LINE) ? ST_RESP1 : ST_REQ;
`endif
            ST_REQ:   if (req_ready) next_state = ST_WAIT;
            ST_WAIT:  if (resp_valid) next_state = ST_RESP1;
            ST_RESP1: next_state = (cmd_q == C1_READ32) ? ST_RESP2 : ST_IDLE;
            ST_RESP2: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Bus drive is computed from the state being entered so the flopped pads line up with it.
    always_comb begin
        cmd_oe_d   = 1'b0;
        cmd_drv_d  = 3'd0;
        data_oe_d  = 1'b0;
        data_drv_d = '0;
        if (next_state == ST_RESP1 || next_state == ST_RESP2) begin
            cmd_oe_d  = 1'b1;
            cmd_drv_d = C1_WRITE32_RESP;
        end
        if (next_state == ST_RESP1 && is_read(cmd_q)) begin
            data_oe_d  = 1'b1;
            data_drv_d = (cmd_q == C1_READ8) ? {{(BUS_SIZE-8){1'b0}}, resp_rdata[7:0]}
                                             : resp_rdata[BUS_SIZE-1:0];
        end
        if (next_state == ST_RESP2) begin
            data_oe_d  = 1'b1;
            data_drv_d = rdata_q[2*BUS_SIZE-1:BUS_SIZE];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_q     <= C1_NOP;
            tag_set_q <= '0;
            offset_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (next_state == ST_ADDR2) begin
                        cmd_q     <= c1_cmd_e'(command);
                        tag_set_q <= address;
                        wdata_q   <= (command == C1_WRITE8)
                                   ? {{(2*BUS_SIZE-8){1'b0}}, data[7:0]}
                                   : {{BUS_SIZE{1'b0}}, data};
                    end
                end
                ST_ADDR2: begin
                    offset_q <= address[CACHE_OFFSET_SIZE-1:0];
                    if (cmd_q == C1_WRITE32) wdata_q[2*BUS_SIZE-1:BUS_SIZE] <= data;
                end
                ST_WAIT: if (resp_valid) rdata_q <= resp_rdata;
                default: ;
            endcase
        end
    end

    c1_tristate #(.W(3)) u_command (
        .clk   (clk),
        .reset (reset),
        .d     (cmd_drv_d),
        .oe_d  (cmd_oe_d),
        .pad   (command)
    );

    c1_tristate #(.W(BUS_SIZE)) u_data (
        .clk   (clk),
        .reset (reset),
        .d     (data_drv_d),
        .oe_d  (data_oe_d),
        .pad   (data)
    );

endmodule

// File: tb/tb_c1_bus_slave.sv
// Bench for c1_bus_slave: CPU/core drivers, a transaction-level reference model and
// per-scenario tasks comparing the observed request and bus trace with the model.
module tb_c1_bus_slave;
    import c1_pkg::*;

`ifdef C1_SLAVE_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] address;
    wire  [15:0] data;
    wire  [2:0]  command;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [18:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    logic        cpu_oe;
    logic [2:0]  cpu_cmd;
    logic [15:0] cpu_data;

    int checks   = 0;
    int failures = 0;

    // trace entry: {req_valid, cmd_oe, cmd[2:0], data_oe, data[15:0]}
    logic [21:0] obs_q[$];
    logic [21:0] exp_q[$];
    logic        obs_req_seen;
    logic [2:0]  obs_cmd;
    logic [18:0] obs_addr;
    logic [31:0] obs_wdata;
    logic        obs_stable;
    logic        obs_quiet;

    assign command = cpu_oe ? cpu_cmd  : 3'bzzz;
    assign data    = cpu_oe ? cpu_data : 16'hzzzz;

    always #5 clk = ~clk;

    c1_bus_slave dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .data       (data),
        .command    (command),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    function automatic logic [21:0] bus_sample();
        logic [21:0] s;
        s     = '0;
        s[21] = req_valid;
        s[20] = dut.u_command.oe;
        if (dut.u_command.oe) s[19:17] = command;
        s[16] = dut.u_data.oe;
        if (dut.u_data.oe) s[15:0] = data;
        return s;
    endfunction

    function automatic logic bus_quiet();
        return !dut.u_command.oe && !dut.u_data.oe && !req_valid;
    endfunction

    // Reference model: which commands reach the core and what the bus shows after the response.
    task automatic model_txn(input logic [2:0] c, input logic [31:0] r, output logic fwd);
        exp_q.delete();
        fwd = (c != 3'd4) || INV_EN;
        case (c)
            3'd1: exp_q.push_back({2'b01, 3'd7, 1'b1, 8'h00, r[7:0]});
            3'd2: exp_q.push_back({2'b01, 3'd7, 1'b1, r[15:0]});
            3'd3: begin
                exp_q.push_back({2'b01, 3'd7, 1'b1, r[15:0]});
                exp_q.push_back({2'b01, 3'd7, 1'b1, r[31:16]});
            end
            default: exp_q.push_back({2'b01, 3'd7, 1'b0, 16'h0000});
        endcase
        while (exp_q.size() < 3) exp_q.push_back('0);
    endtask

    function automatic logic [31:0] model_wdata(input logic [2:0] c, input logic [15:0] lo,
                                                input logic [15:0] hi);
        case (c)
            3'd5:    return {24'h0, lo[7:0]};
            3'd6:    return {16'h0, lo};
            default: return {hi, lo};
        endcase
    endfunction

    task automatic cpu_phase(input logic [2:0] c, input logic [18:0] a,
                             input logic [15:0] lo, input logic [15:0] hi);
        @(negedge clk);
        cpu_oe   = 1'b1;
        cpu_cmd  = c;
        address  = a[18:4];
        cpu_data = lo;
        @(negedge clk);
        cpu_cmd  = 3'($urandom);
        address  = {11'($urandom), a[3:0]};
        cpu_data = hi;
        @(posedge clk);
        #1;
        cpu_oe  = 1'b0;
        address = 15'($urandom);
    endtask

    task automatic run_txn(input logic [2:0] c, input logic [18:0] a, input logic [15:0] lo,
                           input logic [15:0] hi, input logic [31:0] r,
                           input int ready_delay, input int resp_delay);
        obs_q.delete();
        obs_stable = 1'b1;
        obs_quiet  = 1'b1;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        cpu_phase(c, a, lo, hi);
        @(negedge clk);
        obs_req_seen = req_valid;
        obs_cmd      = req_cmd;
        obs_addr     = req_addr;
        obs_wdata    = req_wdata;
        if (obs_req_seen) begin
            for (int k = 0; k <= ready_delay; k++) begin
                if (k > 0) @(negedge clk);
                if (!(req_valid === 1'b1 && req_cmd === obs_cmd && req_addr === obs_addr &&
                      req_wdata === obs_wdata && !dut.u_command.oe && !dut.u_data.oe))
                    obs_stable = 1'b0;
                req_ready  = (k == ready_delay);
                resp_valid = (k < ready_delay) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
            req_ready = 1'b0;
            for (int k = 0; k <= resp_delay; k++) begin
                if (!bus_quiet()) obs_quiet = 1'b0;
                resp_valid = (k == resp_delay);
                resp_rdata = (k == resp_delay) ? r : $urandom;
                @(negedge clk);
            end
            resp_valid = 1'b0;
            resp_rdata = $urandom;
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            obs_q.push_back(bus_sample());
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        cpu_oe     = 1'b0;
        cpu_cmd    = 3'd0;
        cpu_data   = 16'h0;
        address    = 15'h0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        checks++; if (req_cmd !== 3'd0) begin failures++; $display("FAIL reset_req_cmd: got %h expected 0", req_cmd); end
        checks++; if (req_addr !== 19'h0) begin failures++; $display("FAIL reset_req_addr: got %h expected 0", req_addr); end
        checks++; if (req_wdata !== 32'h0) begin failures++; $display("FAIL reset_req_wdata: got %h expected 0", req_wdata); end
        checks++; if (dut.u_command.oe !== 1'b0) begin failures++; $display("FAIL reset_command_drive: got %b expected 0", dut.u_command.oe); end
        checks++; if (dut.u_data.oe !== 1'b0) begin failures++; $display("FAIL reset_data_drive: got %b expected 0", dut.u_data.oe); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read32();
        logic fwd;
        run_txn(3'd3, 19'b0000000000_01110_0000, 16'($urandom), 16'($urandom), 32'h5555AAAA, 0, 2);
        model_txn(3'd3, 32'h5555AAAA, fwd);
        checks++; if (obs_req_seen !== fwd) begin failures++; $display("FAIL read32_req_seen: got %b expected %b", obs_req_seen, fwd); end
        checks++; if (obs_addr !== 19'h000E0) begin failures++; $display("FAIL read32_req_addr: got %h expected 000e0", obs_addr); end
        checks++; if (obs_cmd !== 3'd3) begin failures++; $display("FAIL read32_req_cmd: got %h expected 3", obs_cmd); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL read32_trace[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_write32();
        logic fwd;
        run_txn(3'd7, 19'($urandom), 16'h0F0F, 16'hF0F0, $urandom, 1, 0);
        model_txn(3'd7, 32'h0, fwd);
        checks++; if (obs_wdata !== 32'hF0F00F0F) begin failures++; $display("FAIL write32_wdata: got %h expected f0f00f0f", obs_wdata); end
        checks++; if (obs_cmd !== 3'd7) begin failures++; $display("FAIL write32_req_cmd: got %h expected 7", obs_cmd); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL write32_trace[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_read8();
        logic fwd;
        run_txn(3'd1, 19'($urandom), 16'($urandom), 16'($urandom), 32'h123456AB, 0, 0);
        model_txn(3'd1, 32'h123456AB, fwd);
        checks++; if (obs_q[0][15:0] !== 16'h00AB) begin failures++; $display("FAIL read8_data: got %h expected 00ab", obs_q[0][15:0]); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL read8_trace[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic        fwd;
        logic [18:0] a;
        logic [31:0] r;
        a = 19'($urandom);
        r = $urandom;
        run_txn(3'd2, a, 16'($urandom), 16'($urandom), r, 5, 3);
        model_txn(3'd2, r, fwd);
        checks++; if (obs_stable !== 1'b1) begin failures++; $display("FAIL backpressure_stable: got %b expected 1", obs_stable); end
        checks++; if (obs_quiet !== 1'b1) begin failures++; $display("FAIL backpressure_wait_quiet: got %b expected 1", obs_quiet); end
        checks++; if (obs_addr !== a) begin failures++; $display("FAIL backpressure_addr: got %h expected %h", obs_addr, a); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL backpressure_trace[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_inv_line();
        logic        fwd;
        logic [18:0] a;
        a = 19'($urandom);
        run_txn(3'd4, a, 16'($urandom), 16'($urandom), $urandom, 0, 1);
        model_txn(3'd4, 32'h0, fwd);
        checks++; if (obs_req_seen !== fwd) begin failures++; $display("FAIL inv_req_seen: got %b expected %b", obs_req_seen, fwd); end
        if (fwd) begin
            checks++; if (obs_addr !== a) begin failures++; $display("FAIL inv_req_addr: got %h expected %h", obs_addr, a); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL inv_trace[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic        fwd;
        logic [31:0] r;
        // reset while waiting for the core, then a stray completion
        cpu_phase(3'd2, 19'($urandom), 16'($urandom), 16'($urandom));
        @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = $urandom;
        checks++; if (!bus_quiet()) begin failures++; $display("FAIL midreset_release: got %h expected quiet", bus_sample()); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            resp_valid = 1'b0;
            checks++;
            if (!bus_quiet()) begin failures++; $display("FAIL midreset_stray[%0d]: got %h expected quiet", k, bus_sample()); end
        end
        r = $urandom;
        run_txn(3'd2, 19'($urandom), 16'($urandom), 16'($urandom), r, 0, 0);
        model_txn(3'd2, r, fwd);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL after_reset_trace[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        // reset while the response is on the bus
        cpu_phase(3'd3, 19'($urandom), 16'($urandom), 16'($urandom));
        @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = $urandom;
        @(negedge clk);
        resp_valid = 1'b0;
        checks++; if (dut.u_command.oe !== 1'b1) begin failures++; $display("FAIL resp1_drive: got %b expected 1", dut.u_command.oe); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (!bus_quiet()) begin failures++; $display("FAIL resp_reset_release: got %h expected quiet", bus_sample()); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (!bus_quiet()) begin failures++; $display("FAIL resp_reset_no_resp2: got %h expected quiet", bus_sample()); end
    endtask

    task automatic test_random();
        logic        fwd;
        logic [2:0]  c;
        logic [18:0] a;
        logic [15:0] lo, hi;
        logic [31:0] r;
        for (int n = 0; n < 24; n++) begin
            c  = 3'($urandom_range(1, 7));
            a  = 19'($urandom);
            lo = 16'($urandom);
            hi = 16'($urandom);
            r  = $urandom;
            run_txn(c, a, lo, hi, r, $urandom_range(0, 3), $urandom_range(0, 3));
            model_txn(c, r, fwd);
            checks++;
            if (obs_req_seen !== fwd) begin failures++; $display("FAIL rand_req_seen txn %0d: got %b expected %b", n, obs_req_seen, fwd); end
            if (fwd) begin
                checks++;
                if (obs_cmd !== c) begin failures++; $display("FAIL rand_req_cmd txn %0d: got %h expected %h", n, obs_cmd, c); end
                checks++;
                if (obs_addr !== a) begin failures++; $display("FAIL rand_req_addr txn %0d: got %h expected %h", n, obs_addr, a); end
                checks++;
                if (obs_stable !== 1'b1 || obs_quiet !== 1'b1) begin failures++; $display("FAIL rand_handshake txn %0d: got %b%b expected 11", n, obs_stable, obs_quiet); end
                if (c >= 3'd5) begin
                    checks++;
                    if (obs_wdata !== model_wdata(c, lo, hi)) begin failures++; $display("FAIL rand_wdata txn %0d: got %h expected %h", n, obs_wdata, model_wdata(c, lo, hi)); end
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_trace[%0d] txn %0d: got %h expected %h", i, n, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read32();
        test_write32();
        test_read8();
        test_backpressure();
        test_inv_line();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/c1_bus_slave.md
# c1_bus_slave

Cache-side front end of the CPU↔cache C1 bus. Samples the CPU's two-cycle command/address phase, reassembles the full byte address and write data, and hands a single request to the cache core over a valid/ready handshake. When the core answers, it owns the shared `command`/`data` lines and drives the `C1_WRITE32_RESP` response, including the two-word READ32 return, then releases the bus.

## Interface
- `MEM_ADDR_SIZE`, 19, full byte-address width
- `BUS_SIZE`, 16, C1 data-bus width
- `CACHE_OFFSET_SIZE`, 4, line-offset width; address bus is `MEM_ADDR_SIZE-CACHE_OFFSET_SIZE` bits
- `clk`  in  1  single clock; bus sampled on posedge
- `reset`  in  1  synchronous, active-high reset
- `address`  in  MEM_ADDR_SIZE-CACHE_OFFSET_SIZE  C1 address bus (tag+set, then offset in low bits)
- `data`  inout  BUS_SIZE  C1 data bus
- `command`  inout  3  C1 command bus
- `req_valid`  out  1  request to core pending
- `req_ready`  in  1  core accepts request
- `req_cmd`  out  3  C1 command code of request
- `req_addr`  out  MEM_ADDR_SIZE  {tag_set, offset}
- `req_wdata`  out  2*BUS_SIZE  write data, zero-extended for 8/16-bit
- `resp_valid`  in  1  one-cycle core completion pulse
- `resp_rdata`  in  2*BUS_SIZE  read data, valid with `resp_valid`

## Operation
- States: IDLE, ADDR2, REQ, WAIT, RESP1, RESP2.
- IDLE: `command` sampled. Codes 1–7 start a transaction. 0, X, or Z count as NOP. Capture cmd, `address` as tag_set, and `data` as wdata low word. Go to ADDR2.
- ADDR2: capture `address[CACHE_OFFSET_SIZE-1:0]` as offset. If cmd is WRITE32 (7), capture `data` as wdata high word. Go to REQ.
- REQ: `req_valid`=1, fields stable. Go to WAIT when `req_valid && req_ready`.
- WAIT: go to RESP1 on `resp_valid`, which latches `resp_rdata`. `resp_valid` outside WAIT is ignored.
- RESP1: drive `command`=7.
  - READ8/16/32: drive `data` with the low word. READ8 drives `{8'b0, rdata[7:0]}`.
  - Writes and INV_LINE: `data` stays Z.
  - READ32 goes to RESP2. All others go to IDLE.
- RESP2: drive `command`=7 and `data`=high word. Go to IDLE.
- The block never drives `command`/`data` outside RESP1/RESP2. `command` is ignored in every state except IDLE.
- `reset` mid-transaction:
  - state goes to IDLE
  - `req_valid` deasserts
  - buses release in the same cycle
  - an already-accepted core request is abandoned, and a later `resp_valid` is ignored.

## Timing
- Reset values:
  - `req_valid`=0
  - `req_cmd`=0
  - `req_addr`=0
  - `req_wdata`=0
  - `command` Z
  - `data` Z
- A1 sampled at edge t, A2 at t+1, `req_valid` high from t+2.
- Response: `resp_valid` at edge r, so `command`=7 is driven from r+1 for 1 cycle, or 2 cycles for READ32. Bus is Z at the edge after the last RESP cycle.
- Minimum latency from A1 to first RESP cycle is 4 cycles (`req_ready` tied high, `resp_valid` one cycle after accept).
- The CPU releases `command` after A2, so no bus contention is possible with a compliant master.

## Configuration
- `C1_SLAVE_INV_EN` defined: INV_LINE (4) is forwarded to the core like any request, and the response is one RESP cycle with no data.
- `C1_SLAVE_INV_EN` undefined: INV_LINE is never forwarded (`req_valid` stays 0). The block goes from ADDR2 directly to RESP1 and acknowledges with one RESP cycle.

## Structure
- Package `c1_pkg` holds:
  - C1 command codes C1_NOP … C1_WRITE32_RESP as a 3-bit enum
  - state enum
  - default width constants
- Sub-module `c1_tristate`: registered value plus output-enable to `inout`. Instantiated for `command` and for `data`.

## Test plan
- READ32 at 19'b0000000000_01110_0000; core returns 32'h5555AAAA after 3 cycles:
  - `req_addr`=19'h000E0, `req_cmd`=3
  - bus shows RESP/16'hAAAA, then RESP/16'h5555, then Z.
- WRITE32 with low 16'h0F0F, high 16'hF0F0 → `req_wdata`=32'hF0F00F0F. One RESP cycle, `data` Z throughout the response.
- READ8 with `resp_rdata`=32'h1234_56AB → single RESP cycle, `data`=16'h00AB.
- `req_ready` held low 5 cycles → `req_valid` and fields stable, no bus drive. RESP appears 1 cycle after the delayed `resp_valid`.
- INV_LINE:
  - with `C1_SLAVE_INV_EN`: request seen, RESP after `resp_valid`
  - without it: no request, RESP at A1+2.
- `reset` asserted in WAIT, then a stray `resp_valid` → buses Z, state IDLE, no RESP. A following READ16 completes normally.
